tone_sequencer_multi: RTL
=========================

# tone_sequencer_multi

Parametrised, multi-voice successor to the single-channel music processor. It plays NUM_VOICES independent square-wave note sequences from a writable song RAM, with note durations timed in milliseconds via `ticks_per_milli`. It produces one mixed speaker output, per-voice outputs and an 8-bit status LED bus. It sits directly under the tile top level, taking the place of the single-voice player.

## Interface
- NUM_VOICES, 2: independent voices, 1..4
- SONG_DEPTH, 32: note entries per voice, power of two, 2..64; ADDR_W = clog2(SONG_DEPTH)
- PERIOD_W, 16: half-period field width, in clock cycles
- DUR_W, 8: duration field width, in ms
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ticks_per_milli  in  16  clock cycles per millisecond
- play  in  1  level: 1 = run all voices, 0 = abort/idle
- wr_en  in  1  song RAM write strobe
- wr_voice  in  2  target voice; indices >= NUM_VOICES are ignored
- wr_addr  in  ADDR_W  entry address
- wr_data  in  PERIOD_W+DUR_W  entry = {half_period, duration}
- voice_out  out  NUM_VOICES  per-voice square wave
- sound  out  1  time-multiplexed mix
- led  out  8  {any_playing, all_done, 0-padded voice-0 address in [5:0]}

## Operation
- ms tick: counter 0..N-1 with N = max(ticks_per_milli, 1); `ms_tick` pulses 1 cycle when counter >= N-1, then the counter clears. Using >= makes a mid-run decrease of ticks_per_milli wrap safely.
- Entry: half_period = 0 means rest (voice held 0). duration = 0 means end-of-song marker.
- Per-voice FSM: IDLE, LOAD, PLAY, DONE.
  - IDLE: addr = 0, output 0. Goes to LOAD when play = 1.
  - LOAD: registered RAM read of entry[addr] takes 1 cycle, then:
    - duration = 0: go to DONE (or see Configuration).
    - otherwise: go to PLAY with dur_cnt = duration, phase_cnt = 0, output 0.
  - PLAY: phase_cnt increments each cycle. At half_period-1 it clears and the output toggles (if half_period != 0). On ms_tick, dur_cnt decrements; when dur_cnt = 1 and ms_tick, addr increments (wraps at SONG_DEPTH) and the FSM goes to LOAD.
  - DONE: output 0. Stays until play = 0.
  - play = 0 in any state: go to IDLE on the next edge, with output and addr cleared.
- Voices are independent; each ends at its own marker.
- Mix: mix_sel increments every cycle modulo NUM_VOICES. `sound` is a registered copy of voice_out[mix_sel].
- any_playing = some voice in LOAD or PLAY. all_done = every voice in DONE.
- Writes are accepted in any state and take effect the next time that address is loaded. A write and a LOAD read of the same address in the same cycle returns the old data.

## Timing
- Reset values: voice_out = 0, sound = 0, led = 0x00. All FSMs are in IDLE, all counters are 0, and RAM contents are undefined.
- play rises at edge 0: LOAD at edge 1, PLAY at edge 2. The first toggle of a non-rest note occurs half_period cycles after entering PLAY.
- Note length: duration full ms_tick periods from PLAY entry (the first tick may be partial), plus 1 LOAD cycle per note.
- `sound` lags voice_out by 1 cycle.
- rst may assert mid-note and takes effect immediately. RAM is not cleared by reset.

## Configuration
- TONE_SEQ_LOOP_EN defined: an end marker at addr > 0 restarts that voice at addr 0 (LOAD again, 1 cycle). A marker at addr 0 still goes to DONE, which prevents an endless empty loop. all_done never asserts unless every song is empty.
- Not defined: an end marker always goes to DONE.

## Test plan
- Reset: assert rst with play = 1 -> voice_out = 0, sound = 0, led = 0x00. Release rst -> LOAD next edge.
- Single note: ticks_per_milli = 4, voice 0 entry0 = {3, 2}, entry1 = {0, 0}, voice 1 entry0 = {0, 0}. Pulse play high -> voice_out[0] toggles every 3 cycles for about 8 cycles, then DONE. led[6] = 1 once both voices are done.
- Rest and advance: entry0 = {0, 1}, entry1 = {2, 1}, entry2 = end -> output 0 for ~4 cycles, then toggles every 2 cycles. led[5:0] steps 0→1→2.
- Abort: drop play mid-note -> voice_out = 0 and led[5:0] = 0 one edge later. Re-raise play -> replays from entry0.
- Mix: NUM_VOICES = 2, voice 0 held high and voice 1 low -> sound alternates 1/0 every cycle, delayed by 1 cycle.
- Loop macro: with TONE_SEQ_LOOP_EN and song {5, 1}, end -> addr returns to 0 after entry1 and playback continues. Without the macro -> DONE.

Source files
------------

// File: rtl/tone_sequencer_multi.sv
// Multi-voice square-wave tone sequencer fed from a writable per-voice song RAM.
// Define TONE_SEQ_LOOP_EN to restart non-empty songs at entry 0 instead of stopping.
module tone_sequencer_multi #(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned SONG_DEPTH = 32,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned DUR_W      = 8,
  localparam int unsigned ADDR_W    = $clog2(SONG_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [15:0]               ticks_per_milli_i,
  input  logic                      play_i,
  input  logic                      wr_en_i,
  input  logic [1:0]                wr_voice_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [PERIOD_W+DUR_W-1:0] wr_data_i,
  output logic [NUM_VOICES-1:0]     voice_out_o,
  output logic                      sound_o,
  output logic [7:0]                led_o
);

  localparam int unsigned EntryW = PERIOD_W + DUR_W;
  localparam int unsigned MixW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

  // Millisecond tick; >= keeps a shrinking ticks_per_milli from overshooting.
  logic [15:0] tick_q, tick_d, tick_max;
  logic        ms_tick;

  always_comb begin
    tick_max = (ticks_per_milli_i == '0) ? 16'd0 : ticks_per_milli_i - 16'd1;
    ms_tick  = (tick_q >= tick_max);
    tick_d   = ms_tick ? '0 : tick_q + 16'd1;
  end

  logic [NUM_VOICES-1:0] busy_vec, done_vec;
  logic [ADDR_W-1:0]     addr0;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [EntryW-1:0]   mem_q [SONG_DEPTH];
    logic [EntryW-1:0]   rd_q;
    logic [PERIOD_W-1:0] rd_half;
    logic [DUR_W-1:0]    rd_dur;
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PERIOD_W-1:0] half_q, half_d, phase_q, phase_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                out_q, out_d;

    assign {rd_half, rd_dur} = rd_q;

    // Read port follows addr_d so the entry is ready during the LOAD cycle.
    always_ff @(posedge clk_i) begin
      if (wr_en_i && (wr_voice_i == 2'(v))) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_q <= mem_q[addr_d];
    end

    always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      half_d  = half_q;
      phase_d = phase_q;
      dur_d   = dur_q;
      out_d   = out_q;
      if (!play_i) begin
        state_d = StIdle;
        addr_d  = '0;
        phase_d = '0;
        dur_d   = '0;
        out_d   = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            addr_d  = '0;
            out_d   = 1'b0;
            state_d = StLoad;
          end
          StLoad: begin
            if (rd_dur == '0) begin
`ifdef TONE_SEQ_LOOP_EN
              if (addr_q != '0) begin
                addr_d = '0;
              end else begin
                state_d = StDone;
              end
`else
              state_d = StDone;
`endif
            end else begin
              state_d = StPlay;
              half_d  = rd_half;
              dur_d   = rd_dur;
              phase_d = '0;
              out_d   = 1'b0;
            end
          end
          StPlay: begin
            if (half_q != '0) begin
              if (phase_q == half_q - PERIOD_W'(1)) begin
                phase_d = '0;
                out_d   = ~out_q;
              end else begin
                phase_d = phase_q + PERIOD_W'(1);
              end
            end
            if (ms_tick) begin
              if (dur_q == DUR_W'(1)) begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = StLoad;
                out_d   = 1'b0;
              end else begin
                dur_d = dur_q - DUR_W'(1);
              end
            end
          end
          StDone:  out_d = 1'b0;
          default: state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= StIdle;
        addr_q  <= '0;
        half_q  <= '0;
        phase_q <= '0;
        dur_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        addr_q  <= addr_d;
        half_q  <= half_d;
        phase_q <= phase_d;
        dur_q   <= dur_d;
        out_q   <= out_d;
      end
    end

    assign voice_out_o[v] = out_q;
    assign busy_vec[v]    = (state_q == StLoad) || (state_q == StPlay);
    assign done_vec[v]    = (state_q == StDone);

    if (v == 0) begin : g_addr0
      assign addr0 = addr_q;
    end
  end

  logic [MixW-1:0] mix_q, mix_d;
  logic            sound_q;

  assign mix_d = (mix_q == MixW'(NUM_VOICES - 1)) ? '0 : mix_q + MixW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q  <= '0;
      mix_q   <= '0;
      sound_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      mix_q   <= mix_d;
      sound_q <= voice_out_o[mix_q];
    end
  end

  assign sound_o = sound_q;

  logic [5:0] led_addr;

  always_comb begin
    led_addr             = '0;
    led_addr[ADDR_W-1:0] = addr0;
  end

  assign led_o = {|busy_vec, &done_vec, led_addr};

endmodule
